// File: rtl/code_mem_loader.sv
// code_mem_loader: packs a valid/ready byte stream (length byte, then three bytes per
// word) into 17-bit words and writes them to code memory from address 0.
// While loading, the CPU is held stalled.
// Ports:
//   Clock/Resetn  - clock and asynchronous active-low reset
//   Start         - begin a load
//   Byte_*        - byte stream handshake
//   Wr_*          - code memory write port
//   Cpu_Hold, Busy, Done, Err, Word_Count - status
// Optional build macro: LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte.
module code_mem_loader #(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 17
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic [7:0]        Byte_In,
  input  logic              Byte_Valid,
  output logic              Byte_Ready,
  output logic              Wr_En,
  output logic [ADDR_W-1:0] Wr_Addr,
  output logic [WORD_W-1:0] Wr_Data,
  output logic              Cpu_Hold,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W:0]   Word_Count
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_LEN   = 4'd1;
  localparam logic [3:0] S_B0    = 4'd2;
  localparam logic [3:0] S_B1    = 4'd3;
  localparam logic [3:0] S_B2    = 4'd4;
  localparam logic [3:0] S_WRITE = 4'd5;
  localparam logic [3:0] S_DONE  = 4'd6;
  localparam logic [3:0] S_ERR   = 4'd7;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [3:0] S_CHK   = 4'd8;
  localparam logic [3:0] S_FIN   = S_CHK;
`else
  localparam logic [3:0] S_FIN   = S_DONE;
`endif

  localparam int unsigned MAX_N = 2 ** ADDR_W;

  logic [3:0]      state;
  logic [3:0]      nxt;
  logic [ADDR_W:0] n_len;
  logic [ADDR_W:0] cnt_inc;
  logic [31:0]     len_val;
  logic            xfer;
  logic            start_ok;
  logic            len_ok;
  logic            b0_ok;
  logic            last;
  logic            rdy_n;
  logic            idle_n;
  logic            hold_n;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      sum;
`endif

  assign xfer     = Byte_Valid & Byte_Ready;
  assign start_ok = Start & ((state == S_IDLE) |
                             (state == S_DONE) |
                             (state == S_ERR));
  assign len_val  = {24'd0, Byte_In};
  assign len_ok   = (len_val != 32'd0) && (len_val <= MAX_N);
  assign b0_ok    = (Byte_In[7:1] == 7'd0);
  assign cnt_inc  = Word_Count + (ADDR_W+1)'(1);
  assign last     = (cnt_inc == n_len);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR:
        if (Start) nxt = S_LEN;
      S_LEN:
        if (xfer) nxt = len_ok ? S_B0 : S_ERR;
      S_B0:
        if (xfer) nxt = b0_ok ? S_B1 : S_ERR;
      S_B1:
        if (xfer) nxt = S_B2;
      S_B2:
        if (xfer) nxt = S_WRITE;
      S_WRITE:
        nxt = last ? S_FIN : S_B0;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:
        if (xfer) nxt = (Byte_In == sum) ? S_DONE : S_ERR;
`endif
      default:
        nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so that
  // Byte_Ready never depends combinationally on Byte_Valid.
  always_comb begin
    rdy_n  = (nxt == S_LEN) || (nxt == S_B0) ||
             (nxt == S_B1)  || (nxt == S_B2);
`ifdef LOADER_CHECKSUM_EN
    rdy_n  = rdy_n || (nxt == S_CHK);
`endif
    idle_n = (nxt == S_IDLE) || (nxt == S_DONE) ||
             (nxt == S_ERR);
    // A failed load leaves memory partly written: keep the CPU held.
    hold_n = !((nxt == S_IDLE) || (nxt == S_DONE));
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= S_IDLE;
      Byte_Ready <= 1'b0;
      Wr_En      <= 1'b0;
      Wr_Addr    <= '0;
      Wr_Data    <= '0;
      Cpu_Hold   <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Err        <= 1'b0;
      Word_Count <= '0;
      n_len      <= '0;
    end else begin
      state      <= nxt;
      Byte_Ready <= rdy_n;
      Wr_En      <= (nxt == S_WRITE);
      Busy       <= !idle_n;
      Cpu_Hold   <= hold_n;
      Done       <= (nxt == S_DONE);
      Err        <= (nxt == S_ERR);
      if (start_ok) begin
        Word_Count <= '0;
        Wr_Addr    <= '0;
      end
      // Wr_Addr wraps to 0 after word 2^ADDR_W; the load ends there.
      if (state == S_WRITE) begin
        Word_Count <= cnt_inc;
        Wr_Addr    <= Wr_Addr + ADDR_W'(1);
      end
      if (xfer) begin
        case (state)
          S_LEN: n_len <= len_val[ADDR_W:0];
          S_B0:  if (b0_ok) Wr_Data[WORD_W-1] <= Byte_In[0];
          S_B1:  Wr_Data[15:8] <= Byte_In;
          S_B2:  Wr_Data[7:0]  <= Byte_In;
          default: ;
        endcase
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sum <= '0;
    end else if (start_ok) begin
      sum <= '0;
    end else if (xfer && ((state == S_B0) ||
                          (state == S_B1) ||
                          (state == S_B2))) begin
      sum <= sum + Byte_In;
    end
  end
`endif

endmodule

// File: tb/tb_code_mem_loader.sv
// tb_code_mem_loader: randomized self-checking bench for code_mem_loader.
// Expected writes and status come from a stream-level model of the load format.
module tb_code_mem_loader;
  localparam int AW = 5;
  localparam int WW = 17;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic          Start = 1'b0;
  logic [7:0]    Byte_In = 8'd0;
  logic          Byte_Valid = 1'b0;
  logic          Byte_Ready;
  logic          Wr_En;
  logic [AW-1:0] Wr_Addr;
  logic [WW-1:0] Wr_Data;
  logic          Cpu_Hold;
  logic          Busy;
  logic          Done;
  logic          Err;
  logic [AW:0]   Word_Count;

  int n_pass = 0;
  int n_tot  = 0;

  logic [7:0]    stream[$];
  logic [AW-1:0] got_a[$];
  logic [WW-1:0] got_d[$];

  code_mem_loader #(.ADDR_W(AW), .WORD_W(WW)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start),
    .Byte_In(Byte_In), .Byte_Valid(Byte_Valid),
    .Byte_Ready(Byte_Ready), .Wr_En(Wr_En),
    .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
    .Cpu_Hold(Cpu_Hold), .Busy(Busy), .Done(Done),
    .Err(Err), .Word_Count(Word_Count)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock)
    if (Resetn && Wr_En) begin
      got_a.push_back(Wr_Addr);
      got_d.push_back(Wr_Data);
    end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not end, time %0t", $time);
    $fatal(1);
  end

  task automatic do_start();
    @(posedge Clock);
    #1 Start = 1'b1;
    @(posedge Clock);
    #1 Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic r;
    int k;
    repeat (gap) @(posedge Clock);
    #1 Byte_In = b;
    Byte_Valid = 1'b1;
    r = 1'b0;
    k = 0;
    while (!r && k < 200) begin
      @(negedge Clock);
      r = Byte_Ready;
      @(posedge Clock);
      k++;
    end
    #1 Byte_Valid = 1'b0;
    if (!r) begin
      n_tot++;
      $display("FAIL byte_accept: byte %h not taken, ready=%b", b, r);
    end
  endtask

  task automatic add_chk();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] s;
    s = 8'd0;
    for (int j = 1; j < stream.size(); j++) s = s + stream[j];
    stream.push_back(s);
`endif
  endtask

  task automatic build_load(input logic [7:0] len, input int nw,
                            input int bad_at);
    stream.delete();
    stream.push_back(len);
    for (int i = 0; i < nw; i++) begin
      if (i == bad_at) stream.push_back(8'($urandom_range(2, 255)));
      else stream.push_back(8'($urandom_range(0, 1)));
      stream.push_back(8'($urandom));
      stream.push_back(8'($urandom));
    end
    if (bad_at < 0) add_chk();
  endtask

  task automatic check_zero(input string tag);
    n_tot++;
    if ({Byte_Ready, Wr_En, Wr_Addr, Wr_Data, Cpu_Hold, Busy,
         Done, Err, Word_Count} !== '0)
      $display("FAIL %s: outputs rdy%b we%b a%h d%h hold%b busy%b done%b err%b cnt%0d, want all 0",
               tag, Byte_Ready, Wr_En, Wr_Addr, Wr_Data, Cpu_Hold,
               Busy, Done, Err, Word_Count);
    else n_pass++;
  endtask

  task automatic apply_reset();
    #3 Resetn = 1'b0;
    Byte_Valid = 1'b0;
    Start = 1'b0;
    #1 check_zero("reset_async");
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  // Model: decode the stream by its format rules, then send it and compare.
  task automatic run_stream(input string tag, input int gmax);
    logic [AW-1:0] ea[$];
    logic [WW-1:0] ed[$];
    logic [7:0]    b0;
    int n, cons, cnt, k;
    bit e;
    n = int'(stream[0]);
    e = 1'b0;
    cons = 1;
    cnt = 0;
    if (n < 1 || n > 32) e = 1'b1;
    else begin
      for (int i = 0; i < n && !e; i++) begin
        b0 = stream[1+3*i];
        cons++;
        if (b0 > 8'd1) e = 1'b1;
        else begin
          ea.push_back(AW'(i));
          ed.push_back({b0[0], stream[2+3*i], stream[3+3*i]});
          cons += 2;
          cnt++;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      if (!e) begin
        logic [7:0] s;
        s = 8'd0;
        for (int j = 1; j <= 3*n; j++) s = s + stream[j];
        cons++;
        if (stream[3*n+1] != s) e = 1'b1;
      end
`endif
    end
    got_a.delete();
    got_d.delete();
    do_start();
    for (int j = 0; j < cons; j++)
      send_byte(stream[j], $urandom_range(0, gmax));
    k = 0;
    while (Busy === 1'b1 && k < 300) begin
      @(negedge Clock);
      k++;
    end
    @(negedge Clock);
    n_tot++;
    if (Busy !== 1'b0) $display("FAIL %s busy_end: got %b want 0", tag, Busy);
    else n_pass++;
    n_tot++;
    if (Done !== !e) $display("FAIL %s done: got %b want %b", tag, Done, !e);
    else n_pass++;
    n_tot++;
    if (Err !== e) $display("FAIL %s err: got %b want %b", tag, Err, e);
    else n_pass++;
    n_tot++;
    if (Cpu_Hold !== e)
      $display("FAIL %s hold: got %b want %b", tag, Cpu_Hold, e);
    else n_pass++;
    n_tot++;
    if (Word_Count !== (AW+1)'(cnt))
      $display("FAIL %s count: got %0d want %0d", tag, Word_Count, cnt);
    else n_pass++;
    n_tot++;
    if (Byte_Ready !== 1'b0)
      $display("FAIL %s ready_end: got %b want 0", tag, Byte_Ready);
    else n_pass++;
    n_tot++;
    if (got_a.size() != ea.size())
      $display("FAIL %s nwrites: got %0d want %0d", tag, got_a.size(), ea.size());
    else n_pass++;
    for (int i = 0; i < ea.size() && i < got_a.size(); i++) begin
      n_tot++;
      if (got_a[i] !== ea[i] || got_d[i] !== ed[i])
        $display("FAIL %s write%0d: got %h@%0d want %h@%0d",
                 tag, i, got_d[i], got_a[i], ed[i], ea[i]);
      else n_pass++;
    end
    if (!e) begin
      n_tot++;
      if (Wr_Addr !== AW'(n) || Wr_Data !== ed[n-1])
        $display("FAIL %s final: got %h@%0d want %h@%0d",
                 tag, Wr_Data, Wr_Addr, ed[n-1], AW'(n));
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    #2 check_zero("reset_hold");
    #10 Resetn = 1'b1;
    repeat (3) @(negedge Clock);
    check_zero("idle");
  endtask

  task automatic test_idle_start();
    do_start();
    @(negedge Clock);
    n_tot++;
    if ({Busy, Cpu_Hold, Byte_Ready, Done, Err} !== 5'b11100)
      $display("FAIL start_state: busy/hold/rdy/done/err got %b want 11100",
               {Busy, Cpu_Hold, Byte_Ready, Done, Err});
    else n_pass++;
    repeat (20) @(negedge Clock);
    n_tot++;
    if ({Busy, Byte_Ready, Wr_En} !== 3'b110)
      $display("FAIL start_wait: busy/rdy/we got %b want 110",
               {Busy, Byte_Ready, Wr_En});
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_three_words();
    stream = {8'h03, 8'h01, 8'hF4, 8'h00, 8'h00, 8'h05, 8'h01,
              8'h01, 8'hEE, 8'h00};
    add_chk();
    run_stream("three", 0);
    n_tot++;
    if (got_d.size() != 3 || got_d[0] !== 17'h1F400 ||
        got_d[1] !== 17'h00501 || got_d[2] !== 17'h1EE00)
      $display("FAIL three_data: got %0d writes, first %h want 1f400/00501/1ee00",
               got_d.size(), (got_d.size() > 0) ? got_d[0] : 17'h0);
    else n_pass++;
  endtask

  task automatic test_bad_len();
    stream = {8'h00};
    run_stream("len0", 1);
    stream = {8'h21};
    run_stream("len33", 1);
  endtask

  task automatic test_bad_b0();
    stream = {8'h01, 8'h02};
    run_stream("bad_b0", 0);
    stream = {8'h01, 8'h01, 8'hAB, 8'hCD};
    add_chk();
    run_stream("recover", 0);
  endtask

  task automatic test_start_wins();
    @(posedge Clock);
    #1 Start = 1'b1;
    Byte_Valid = 1'b1;
    Byte_In = 8'h00;
    @(posedge Clock);
    #1 Start = 1'b0;
    Byte_Valid = 1'b0;
    @(negedge Clock);
    n_tot++;
    if ({Busy, Byte_Ready, Done, Err} !== 4'b1100)
      $display("FAIL start_wins: busy/rdy/done/err got %b want 1100",
               {Busy, Byte_Ready, Done, Err});
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_full_32();
    build_load(8'd32, 32, -1);
    run_stream("full32", 3);
  endtask

  task automatic test_random();
    int r, n;
    for (int t = 0; t < 8; t++) begin
      r = $urandom_range(0, 99);
      if (r < 5) build_load(8'd0, 0, -1);
      else if (r < 15) build_load(8'($urandom_range(33, 255)), 0, -1);
      else begin
        n = $urandom_range(1, 32);
        build_load(8'(n), n,
                   ($urandom_range(0, 9) == 0) ? $urandom_range(0, n-1) : -1);
      end
      run_stream("random", 2);
    end
  endtask

  task automatic test_reset_midload();
    build_load(8'd5, 5, -1);
    got_a.delete();
    got_d.delete();
    do_start();
    for (int j = 0; j < 7; j++) send_byte(stream[j], 0);
    repeat (3) @(negedge Clock);
    n_tot++;
    if (got_a.size() != 2)
      $display("FAIL mid_writes: got %0d want 2", got_a.size());
    else n_pass++;
    #2 Resetn = 1'b0;
    #1 check_zero("mid_reset");
    #4 Resetn = 1'b1;
    build_load(8'd2, 2, -1);
    run_stream("reload", 1);
    n_tot++;
    if (got_a.size() == 0 || got_a[0] !== '0)
      $display("FAIL reload_addr0: got %0d writes, first addr %0d want 0",
               got_a.size(), (got_a.size() > 0) ? got_a[0] : '0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_idle_start();
    test_three_words();
    test_bad_len();
    test_bad_b0();
    test_start_wins();
    test_full_32();
    test_random();
    test_reset_midload();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
